trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_mem.sv | 33 +++
 rtl/trace_capture.sv | 174 +++++++++++++++++
 tb/tb_trace_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg: shared state encoding and size defaults for trace capture |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam int C_WIDTH = 16;
  localparam int C_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_READ = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trace_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_mem: DEPTH x WIDTH flop array, sync write, async read          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_mem
  import trace_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int DEPTH = C_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  // Contents are deliberately unreset; validity is tracked by the fill count.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_capture: triggered pre/post sample capture with stream readout |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_capture
  import trace_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int DEPTH = C_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] probe,
  input  logic             probe_valid,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [AW-1:0]    post_count,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic [AW-1:0]    trig_index,
  output logic             busy
);

  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
  localparam logic [AW:0]   C_FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL     = (AW+1)'(DEPTH);

  state_t           r_state;
  state_t           w_next_state;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_fill;
  logic [WIDTH-1:0] r_trig_value;
  logic [WIDTH-1:0] r_trig_mask;
  logic [AW-1:0]    r_post_rem;
  logic [AW-1:0]    r_trig_slot;
  logic [AW-1:0]    r_rd_idx;

  logic             w_hit;
  logic             w_wr_en;
  logic             w_arm_go;
  logic             w_rd_xfer;
  logic             w_full;
  logic             w_last;
  logic [AW-1:0]    w_oldest;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_mem_rd_data;

  // A zero mask bit makes that bit a don't-care; an all-zero mask always hits.
  assign w_hit     = ((probe ^ r_trig_value) & r_trig_mask) == '0;
  assign w_arm_go  = (r_state == ST_IDLE) && arm && !abort;
  assign w_full    = (r_fill == C_FULL);
  // Once the buffer has wrapped, the oldest sample sits where the next write would go.
  assign w_oldest  = w_full ? r_wr_ptr : '0;
  assign w_rd_addr = w_oldest + r_rd_idx;
  assign w_last    = ({1'b0, r_rd_idx} == (r_fill - C_FILL_ONE));
  assign w_rd_xfer = rd_valid && rd_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_next_state = ST_PRE;
        end
      end
      ST_PRE: begin
        if (probe_valid && w_hit) begin
          w_next_state = (r_post_rem == '0) ? ST_READ : ST_POST;
        end
      end
      ST_POST: begin
        if (probe_valid && (r_post_rem == C_PTR_ONE)) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (w_rd_xfer && w_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (abort) begin
      w_next_state = ST_IDLE;
    end
  end

  always_comb begin
    busy     = 1'b0;
    rd_valid = 1'b0;
    w_wr_en  = 1'b0;
    case (r_state)
      ST_PRE, ST_POST: begin
        busy    = 1'b1;
        w_wr_en = probe_valid && !abort;
      end
      ST_READ: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    rd_last    = rd_valid && w_last;
    rd_data    = rd_valid ? w_mem_rd_data : '0;
    trig_index = rd_valid ? (r_trig_slot - w_oldest) : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_trig_value <= '0;
      r_trig_mask  <= '0;
      r_post_rem   <= '0;
      r_trig_slot  <= '0;
      r_rd_idx     <= '0;
    end else begin
      if (w_arm_go) begin
        r_trig_value <= trig_value;
        r_trig_mask  <= trig_mask;
        r_post_rem   <= post_count;
        r_wr_ptr     <= '0;
        r_fill       <= '0;
        r_rd_idx     <= '0;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (!w_full) begin
          r_fill <= r_fill + C_FILL_ONE;
        end
        if ((r_state == ST_PRE) && w_hit) begin
          r_trig_slot <= r_wr_ptr;
        end
        if (r_state == ST_POST) begin
          r_post_rem <= r_post_rem - C_PTR_ONE;
        end
      end
      if (w_rd_xfer && !w_last) begin
        r_rd_idx <= r_rd_idx + C_PTR_ONE;
      end
    end
  end

  trace_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (CLK),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (probe),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_mem_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trace_capture: directed vector bench for trace_capture (DEPTH 8)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_trace_capture;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int NP = 24;
  localparam int NS = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  probe;
  logic          probe_valid;
  logic          arm;
  logic          abort;
  logic [W-1:0]  trig_value;
  logic [W-1:0]  trig_mask;
  logic [AW-1:0] post_count;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic [AW-1:0] trig_index;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string               name;
    logic [W-1:0]        value;
    logic [W-1:0]        mask;
    logic [AW-1:0]       post;
    int                  n_probes;
    logic [NP-1:0][W-1:0] probes;
    int                  n_exp;
    logic [NP-1:0][W-1:0] exp;
    logic [AW-1:0]       exp_ti;
    int                  stall_at;
  } scen_t;

  scen_t tbl[NS];

  trace_capture #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .probe       (probe),
    .probe_valid (probe_valid),
    .arm         (arm),
    .abort       (abort),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .post_count  (post_count),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .trig_index  (trig_index),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Trigger inputs are scrambled right after the pulse so latching is exercised.
  task automatic do_arm(input logic [W-1:0] value, input logic [W-1:0] mask, input logic [AW-1:0] post);
    trig_value = value;
    trig_mask  = mask;
    post_count = post;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    trig_value = ~value;
    trig_mask  = 16'hFFFF;
    post_count = 3'd7;
  endtask

  task automatic run_scen(input scen_t s);
    do_arm(s.value, s.mask, s.post);
    check({s.name, " busy after arm"}, 32'(busy), 32'd1);
    for (int j = 0; j < s.n_probes; j++) begin
      probe       = s.probes[j];
      probe_valid = 1'b1;
      tick();
      if (j % 2 == 1) begin
        probe_valid = 1'b0;
        probe       = 16'hDEAD;
        tick();
      end
    end
    probe_valid = 1'b0;
    rd_ready    = 1'b0;
    for (int i = 0; i < s.n_exp; i++) begin
      if (i == s.stall_at) begin
        for (int k = 0; k < 3; k++) begin
          check({s.name, " stall valid"}, 32'(rd_valid), 32'd1);
          check({s.name, " stall data"}, 32'(rd_data), 32'(s.exp[i]));
          tick();
        end
      end
      check({s.name, " rd_valid"}, 32'(rd_valid), 32'd1);
      check({s.name, " rd_data"}, 32'(rd_data), 32'(s.exp[i]));
      check({s.name, " rd_last"}, 32'(rd_last), 32'(i == s.n_exp - 1));
      check({s.name, " trig_index"}, 32'(trig_index), 32'(s.exp_ti));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check({s.name, " rd_valid after last"}, 32'(rd_valid), 32'd0);
    check({s.name, " busy after last"}, 32'(busy), 32'd0);
  endtask

  initial begin
    RST         = 1'b0;
    probe       = '0;
    probe_valid = 1'b0;
    arm         = 1'b0;
    abort       = 1'b0;
    trig_value  = '0;
    trig_mask   = '0;
    post_count  = '0;
    rd_ready    = 1'b0;

    foreach (tbl[t]) begin
      tbl[t].probes   = '0;
      tbl[t].exp      = '0;
      tbl[t].stall_at = -1;
    end
    tbl[0].name = "basic"; tbl[0].value = 16'h0003; tbl[0].mask = 16'hFFFF; tbl[0].post = 3'd2;
    tbl[0].n_probes = 5; tbl[0].n_exp = 5; tbl[0].exp_ti = 3'd2; tbl[0].stall_at = 2;
    for (int k = 0; k < 5; k++) begin
      tbl[0].probes[k] = 16'(k + 1);
      tbl[0].exp[k]    = 16'(k + 1);
    end
    tbl[1].name = "wrap"; tbl[1].value = 16'h0010; tbl[1].mask = 16'hFFFF; tbl[1].post = 3'd3;
    tbl[1].n_probes = 20; tbl[1].n_exp = 8; tbl[1].exp_ti = 3'd4;
    for (int k = 0; k < 20; k++) tbl[1].probes[k] = 16'(k);
    for (int k = 0; k < 8; k++) tbl[1].exp[k] = 16'(k + 12);
    tbl[2].name = "mask"; tbl[2].value = 16'h1200; tbl[2].mask = 16'hFF00; tbl[2].post = 3'd1;
    tbl[2].n_probes = 3; tbl[2].n_exp = 3; tbl[2].exp_ti = 3'd1;
    tbl[2].probes[0] = 16'h11FF; tbl[2].probes[1] = 16'h12AB; tbl[2].probes[2] = 16'h12CD;
    tbl[2].exp[0]    = 16'h11FF; tbl[2].exp[1]    = 16'h12AB; tbl[2].exp[2]    = 16'h12CD;
    tbl[3].name = "post0"; tbl[3].value = 16'h0007; tbl[3].mask = 16'hFFFF; tbl[3].post = 3'd0;
    tbl[3].n_probes = 4; tbl[3].n_exp = 3; tbl[3].exp_ti = 3'd2;
    for (int k = 0; k < 4; k++) tbl[3].probes[k] = 16'(k + 5);
    for (int k = 0; k < 3; k++) tbl[3].exp[k] = 16'(k + 5);
    tbl[4].name = "mask0"; tbl[4].value = 16'h5555; tbl[4].mask = 16'h0000; tbl[4].post = 3'd2;
    tbl[4].n_probes = 4; tbl[4].n_exp = 3; tbl[4].exp_ti = 3'd0;
    tbl[4].probes[0] = 16'hAAAA; tbl[4].probes[1] = 16'hBBBB;
    tbl[4].probes[2] = 16'hCCCC; tbl[4].probes[3] = 16'hDDDD;
    tbl[4].exp[0] = 16'hAAAA; tbl[4].exp[1] = 16'hBBBB; tbl[4].exp[2] = 16'hCCCC;

    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_last", 32'(rd_last), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset trig_index", 32'(trig_index), 32'd0);
    RST = 1'b1;
    tick();

    // Valid samples while idle must not start anything.
    probe = 16'h0003;
    probe_valid = 1'b1;
    repeat (3) tick();
    probe_valid = 1'b0;
    check("idle probes busy", 32'(busy), 32'd0);
    check("idle probes rd_valid", 32'(rd_valid), 32'd0);

    for (int t = 0; t < NS; t++) run_scen(tbl[t]);

    // Reset during POST discards the capture.
    do_arm(16'h0003, 16'hFFFF, 3'd4);
    for (int k = 1; k <= 4; k++) begin
      probe = 16'(k);
      probe_valid = 1'b1;
      tick();
    end
    probe_valid = 1'b0;
    check("post busy before reset", 32'(busy), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset rd_valid", 32'(rd_valid), 32'd0);
    tick();
    RST = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      probe = 16'(k);
      probe_valid = 1'b1;
      tick();
    end
    probe_valid = 1'b0;
    check("after reset busy", 32'(busy), 32'd0);
    check("after reset rd_valid", 32'(rd_valid), 32'd0);

    // Arm ignored in READ; abort beats a simultaneous arm.
    do_arm(16'h0001, 16'hFFFF, 3'd0);
    probe = 16'h0001;
    probe_valid = 1'b1;
    tick();
    probe_valid = 1'b0;
    check("single rd_valid", 32'(rd_valid), 32'd1);
    check("single rd_last", 32'(rd_last), 32'd1);
    do_arm(16'h0002, 16'hFFFF, 3'd0);
    check("arm in read rd_valid", 32'(rd_valid), 32'd1);
    check("arm in read rd_data", 32'(rd_data), 32'h0001);
    abort = 1'b1;
    arm   = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    check("abort read rd_valid", 32'(rd_valid), 32'd0);
    check("abort read busy", 32'(busy), 32'd0);

    // Abort beats a simultaneous trigger in PRE.
    do_arm(16'h0005, 16'hFFFF, 3'd0);
    probe = 16'h0005;
    probe_valid = 1'b1;
    abort = 1'b1;
    tick();
    probe_valid = 1'b0;
    abort = 1'b0;
    check("abort trig busy", 32'(busy), 32'd0);
    check("abort trig rd_valid", 32'(rd_valid), 32'd0);

    run_scen(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
